// File: rtl/spi_rx_capture.sv
// SPI receive capture: synchronizes the pad inputs, samples them on a delayed receive strobe,
// packs std/dual/quad groups into 8..32-bit words and hands them off through a one-entry register.
module spi_rx_capture #(
    parameter int CAL_WIDTH   = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic                 en_i,
    input  logic                 lsb_i,
    input  logic [1:0]           spm_i,
    input  logic [1:0]           rdtb_i,
    input  logic [CAL_WIDTH-1:0] cal_i,
    input  logic                 samp_edge_i,
    input  logic [3:0]           spi_io_in_i,
    output logic                 rx_valid_o,
    input  logic                 rx_ready_i,
    output logic [31:0]          rx_data_o,
    output logic                 ovf_o,
    input  logic                 ovf_clr_i,
    output logic                 busy_o
);

    localparam int DLY_LEN = (1 << CAL_WIDTH) - 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [3:0]           sync_q [SYNC_STAGES];
    logic [3:0]           sio;
    logic [DLY_LEN-1:0]   dly_q, dly_d;
    logic [DLY_LEN:0]     taps;
    logic [31:0]          acc_q, acc_d;
    logic [5:0]           cnt_q, cnt_d;
    logic                 valid_q, valid_d;
    logic [31:0]          data_q, data_d;
    logic                 ovf_q, ovf_d;

    logic                 run_ok;
    logic                 strobe;
    logic [5:0]           shift_n;
    logic [31:0]          grp;
    logic [31:0]          acc_shift;
    logic [31:0]          acc_rev;
    logic [5:0]           cnt_sum;
    logic [5:0]           word_w;
    logic                 word_done;
    logic [31:0]          word;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= spi_io_in_i;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign sio = sync_q[SYNC_STAGES-1];

    // Capture only happens in an undisturbed RUN cycle; abort and restart both flush the pipe.
    assign run_ok = (state_q == ST_RUN) && en_i && !start_i;
    assign taps   = {dly_q, samp_edge_i && run_ok};
    assign strobe = run_ok && taps[cal_i];

    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_rev
            assign acc_rev[gi] = acc_shift[31-gi];
        end
    endgenerate

    always_comb begin
        shift_n = 6'd1;
        grp     = {31'b0, sio[1]};
        case (spm_i)
            2'd1: begin
                shift_n = 6'd2;
                grp     = {30'b0, sio[1:0]};
            end
            2'd2: begin
                shift_n = 6'd4;
                grp     = {28'b0, sio};
            end
            default: ;
        endcase
        acc_shift = (acc_q << shift_n) | grp;
        cnt_sum   = cnt_q + shift_n;
        word_w    = {1'b0, rdtb_i, 3'b000} + 6'd8;
        word_done = strobe && (cnt_sum == word_w);
        // Reversing all 32 bits then shifting down aligns the reversal to the word width.
        word      = lsb_i ? (acc_rev >> (6'd32 - word_w))
                          : (acc_shift & (32'hFFFF_FFFF >> (6'd32 - word_w)));
    end

    always_comb begin
        state_d = state_q;
        dly_d   = run_ok ? taps[DLY_LEN-1:0] : '0;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        data_d  = data_q;
        ovf_d   = ovf_q;

        case (state_q)
            ST_IDLE: if (start_i && en_i) state_d = ST_RUN;
            ST_RUN:  if (!en_i) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (!run_ok) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (strobe) begin
            acc_d = word_done ? 32'b0 : acc_shift;
            cnt_d = word_done ? 6'b0 : cnt_sum;
        end

        if (ovf_clr_i) ovf_d = 1'b0;
        if (word_done && (!valid_q || rx_ready_i)) begin
            valid_d = 1'b1;
            data_d  = word;
        end else if (word_done) begin
            ovf_d = 1'b1;
        end else if (valid_q && rx_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            dly_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dly_q   <= dly_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            ovf_q   <= ovf_d;
        end
    end

    assign rx_valid_o = valid_q;
    assign rx_data_o  = data_q;
    assign ovf_o      = ovf_q;
    assign busy_o     = (state_q == ST_RUN) || (|dly_q);

endmodule

// File: tb/tb_spi_rx_capture.sv
// Directed bench for spi_rx_capture: one linear sequence with hand-computed words.
module tb_spi_rx_capture;

    logic        clk;
    logic        rst;
    logic        start;
    logic        en;
    logic        lsb;
    logic [1:0]  spm;
    logic [1:0]  rdtb;
    logic [2:0]  cal;
    logic        samp;
    logic [3:0]  io;
    logic        valid;
    logic        ready;
    logic [31:0] data;
    logic        ovf;
    logic        ovf_clr;
    logic        busy;

    int total = 0;
    int bad   = 0;

    spi_rx_capture #(.CAL_WIDTH(3), .SYNC_STAGES(2)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .en_i        (en),
        .lsb_i       (lsb),
        .spm_i       (spm),
        .rdtb_i      (rdtb),
        .cal_i       (cal),
        .samp_edge_i (samp),
        .spi_io_in_i (io),
        .rx_valid_o  (valid),
        .rx_ready_i  (ready),
        .rx_data_o   (data),
        .ovf_o       (ovf),
        .ovf_clr_i   (ovf_clr),
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("chk %-14s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Hold the group long enough to reach sio, then strobe once.
    task automatic send_grp(input logic [3:0] g, input int extra);
        io = g;
        tick();
        tick();
        samp = 1'b1;
        tick();
        samp = 1'b0;
        repeat (extra) tick();
    endtask

    task automatic send_std(input logic [31:0] v, input int nb, input int extra);
        for (int i = nb - 1; i >= 0; i--) send_grp({2'b00, v[i], 1'b0}, extra);
    endtask

    task automatic send_dual(input logic [31:0] v, input int ng);
        for (int i = ng - 1; i >= 0; i--) send_grp({2'b00, v[2*i +: 2]}, 0);
    endtask

    task automatic send_quad(input logic [31:0] v, input int ng);
        for (int i = ng - 1; i >= 0; i--) send_grp(v[4*i +: 4], 0);
    endtask

    // Pad flips right after the strobe; only a long enough delay sees the new level.
    task automatic cal_bit(input logic oldb, input logic newb);
        io = {2'b00, oldb, 1'b0};
        repeat (3) tick();
        samp = 1'b1;
        tick();
        samp = 1'b0;
        io = {2'b00, newb, 1'b0};
        repeat (4) tick();
    endtask

    task automatic begin_frame();
        en    = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic end_frame();
        en = 1'b0;
        tick();
    endtask

    task automatic drain(input string tag);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        check(tag, {31'b0, valid}, 32'd0);
    endtask

    initial begin
        logic [31:0] v;
        rst = 1'b1; start = 1'b0; en = 1'b0; lsb = 1'b0; spm = 2'd0; rdtb = 2'd0;
        cal = 3'd0; samp = 1'b0; io = 4'h0; ready = 1'b0; ovf_clr = 1'b0;
        tick();
        tick();
        check("rst_valid", {31'b0, valid}, 32'd0);
        check("rst_data",  data,           32'd0);
        check("rst_ovf",   {31'b0, ovf},   32'd0);
        check("rst_busy",  {31'b0, busy},  32'd0);
        rst = 1'b0;
        tick();

        // std, MSB-first, 8-bit
        begin_frame();
        check("std_busy", {31'b0, busy}, 32'd1);
        send_std(32'hA5 >> 1, 7, 0);
        check("std_noword", {31'b0, valid}, 32'd0);
        send_grp(4'b0010, 0);
        check("std_valid", {31'b0, valid}, 32'd1);
        check("std_data",  data, 32'h0000_00A5);
        drain("std_drain");
        end_frame();

        // spm=3 behaves as std, LSB-first 0x1E
        lsb = 1'b1; spm = 2'd3;
        begin_frame();
        v = 32'h1E;
        for (int i = 0; i < 8; i++) send_grp({2'b00, v[i], 1'b0}, 0);
        check("lsb8_data", data, 32'h0000_001E);
        drain("lsb8_drain");
        end_frame();

        // dual, MSB-first, 16-bit
        lsb = 1'b0; spm = 2'd1; rdtb = 2'd1;
        begin_frame();
        send_dual(32'hBEEF, 8);
        check("dual_data", data, 32'h0000_BEEF);
        drain("dual_drain");
        end_frame();

        // quad, LSB-first, 32-bit
        lsb = 1'b1; spm = 2'd2; rdtb = 2'd3;
        begin_frame();
        send_quad(32'h8765_4321, 8);
        check("quad32_data", data, 32'h84C2_A6E1);
        drain("quad32_drain");
        end_frame();

        // quad, MSB-first, 24-bit
        lsb = 1'b0; rdtb = 2'd2;
        begin_frame();
        send_quad(32'h00AB_CDEF, 6);
        check("quad24_data", data, 32'h00AB_CDEF);
        drain("quad24_drain");
        end_frame();

        // restart mid-word drops the partial bits
        spm = 2'd0; rdtb = 2'd0;
        begin_frame();
        send_std(32'h7, 3, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        send_std(32'h5A, 8, 0);
        check("restart_data", data, 32'h0000_005A);
        drain("restart_drain");
        end_frame();

        // calibration delay: cal=3 sees the new level, cal=1 the old one
        cal = 3'd3;
        begin_frame();
        v = 32'h5A;
        for (int i = 7; i >= 0; i--) cal_bit(~v[i], v[i]);
        check("cal3_data", data, 32'h0000_005A);
        drain("cal3_drain");
        end_frame();
        cal = 3'd1;
        begin_frame();
        for (int i = 7; i >= 0; i--) cal_bit(~v[i], v[i]);
        check("cal1_data", data, 32'h0000_00A5);
        drain("cal1_drain");
        end_frame();

        // overflow with rx_ready_i low
        cal = 3'd0;
        begin_frame();
        send_std(32'h11, 8, 0);
        send_std(32'h22, 8, 0);
        check("ovf_valid", {31'b0, valid}, 32'd1);
        check("ovf_data",  data,           32'h0000_0011);
        check("ovf_flag",  {31'b0, ovf},   32'd1);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        check("ovf_xfer",  {31'b0, valid}, 32'd0);
        check("ovf_sticky", {31'b0, ovf},  32'd1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_clr", {31'b0, ovf}, 32'd0);
        // set and clear in the same cycle: set wins
        send_std(32'h33, 8, 0);
        send_std(32'h44 >> 1, 7, 0);
        io = 4'b0000;
        tick();
        tick();
        samp = 1'b1;
        ovf_clr = 1'b1;
        tick();
        samp = 1'b0;
        ovf_clr = 1'b0;
        check("ovf_setwins", {31'b0, ovf}, 32'd1);
        check("ovf_hold",    data, 32'h0000_0033);
        drain("ovf_drain");
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        end_frame();

        // abort after 5 bits of a 16-bit word, then a clean frame
        rdtb = 2'd1;
        begin_frame();
        send_std(32'h16, 5, 0);
        en = 1'b0;
        tick();
        check("abort_busy",  {31'b0, busy},  32'd0);
        check("abort_valid", {31'b0, valid}, 32'd0);
        repeat (3) tick();
        check("abort_quiet", {31'b0, valid}, 32'd0);
        begin_frame();
        send_std(32'h1234, 16, 0);
        check("abort_next", data, 32'h0000_1234);
        drain("abort_drain");
        end_frame();

        // asynchronous reset with a word held, overflow set and a strobe pending
        rdtb = 2'd0; cal = 3'd3;
        begin_frame();
        send_std(32'hC3, 8, 3);
        send_std(32'h3C, 8, 3);
        check("pre_rst_ovf", {31'b0, ovf}, 32'd1);
        io = 4'b0010;
        tick();
        tick();
        samp = 1'b1;
        tick();
        samp = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        check("arst_valid", {31'b0, valid}, 32'd0);
        check("arst_data",  data,           32'd0);
        check("arst_ovf",   {31'b0, ovf},   32'd0);
        check("arst_busy",  {31'b0, busy},  32'd0);
        tick();
        rst = 1'b0;
        repeat (5) tick();
        check("post_rst_valid", {31'b0, valid}, 32'd0);
        check("post_rst_data",  data,           32'd0);
        check("post_rst_busy",  {31'b0, busy},  32'd0);
        en = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
